// File: rtl/fpu_issue_queue.sv
// rtl/fpu_issue_queue.sv - request FIFO, single-issue sequencer and registered response slot for the FPU core
module fpu_issue_queue #(
    parameter int WIDTH     = 32,
    parameter int OP_WIDTH  = 3,
    parameter int TAG_WIDTH = 4,
    parameter int DEPTH     = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [OP_WIDTH-1:0]      req_op,
    input  logic [WIDTH-1:0]         req_a,
    input  logic [WIDTH-1:0]         req_b,
    input  logic [TAG_WIDTH-1:0]     req_tag,
    output logic                     core_start,
    output logic [OP_WIDTH-1:0]      core_op,
    output logic [WIDTH-1:0]         core_a,
    output logic [WIDTH-1:0]         core_b,
    input  logic                     core_busy,
    input  logic                     core_done,
    input  logic [WIDTH-1:0]         core_result,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_result,
    output logic [TAG_WIDTH-1:0]     rsp_tag,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    logic [OP_WIDTH-1:0]  op_mem  [DEPTH];
    logic [WIDTH-1:0]     a_mem   [DEPTH];
    logic [WIDTH-1:0]     b_mem   [DEPTH];
    logic [TAG_WIDTH-1:0] tag_mem [DEPTH];

    logic [AW:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    state_t               state_q, state_d;
    logic [TAG_WIDTH-1:0] inflight_tag_q, inflight_tag_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]     rsp_result_q, rsp_result_d;
    logic [TAG_WIDTH-1:0] rsp_tag_q, rsp_tag_d;

    logic [AW-1:0]        wr_idx, rd_idx;
    logic                 empty, full, push, issue, capture;
    logic [TAG_WIDTH-1:0] head_tag, cap_tag;

    assign wr_idx   = wr_ptr_q[AW-1:0];
    assign rd_idx   = rd_ptr_q[AW-1:0];
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);
    assign head_tag = tag_mem[rd_idx];

    assign req_ready = !full;
    assign push      = req_valid && !full && !flush;
    // The response slot must be empty or draining this edge so a same-cycle done can land in it.
    assign issue     = (state_q == S_IDLE) && !empty && !core_busy
                       && (!rsp_valid_q || rsp_ready) && !flush;
    assign capture   = core_done && (issue || (state_q == S_WAIT));
    assign cap_tag   = (state_q == S_WAIT) ? inflight_tag_q : head_tag;

    assign core_start = issue;
    assign core_op    = op_mem[rd_idx];
    assign core_a     = a_mem[rd_idx];
    assign core_b     = b_mem[rd_idx];

    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_tag    = rsp_tag_q;
    assign count      = wr_ptr_q - rd_ptr_q;

    always_ff @(posedge clk) begin
        if (push) begin
            op_mem[wr_idx]  <= req_op;
            a_mem[wr_idx]   <= req_a;
            b_mem[wr_idx]   <= req_b;
            tag_mem[wr_idx] <= req_tag;
        end
    end

    always_comb begin
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        state_d        = state_q;
        inflight_tag_d = inflight_tag_q;
        rsp_valid_d    = rsp_valid_q;
        rsp_result_d   = rsp_result_q;
        rsp_tag_d      = rsp_tag_q;

        if (flush) begin
            rd_ptr_d = wr_ptr_q;
        end else begin
            if (push)  wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (issue) rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        case (state_q)
            S_IDLE: begin
                if (issue) begin
                    inflight_tag_d = head_tag;
                    if (!core_done) state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (core_done) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (capture) begin
            rsp_valid_d  = 1'b1;
            rsp_result_d = core_result;
            rsp_tag_d    = cap_tag;
        end else if (rsp_ready) begin
            rsp_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            state_q        <= S_IDLE;
            inflight_tag_q <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_result_q   <= '0;
            rsp_tag_q      <= '0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            state_q        <= state_d;
            inflight_tag_q <= inflight_tag_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_result_q   <= rsp_result_d;
            rsp_tag_q      <= rsp_tag_d;
        end
    end
endmodule

// File: tb/tb_fpu_issue_queue.sv
// tb/tb_fpu_issue_queue.sv - bench for fpu_issue_queue with a toy core model and a queue-based scoreboard
module tb_fpu_issue_queue;
    logic        clk = 1'b0;
    logic        reset, flush, req_valid, req_ready, rsp_valid, rsp_ready;
    logic [2:0]  req_op, core_op;
    logic [31:0] req_a, req_b, core_a, core_b, core_result, rsp_result;
    logic [3:0]  req_tag, rsp_tag;
    logic        core_start, core_busy, core_done;
    logic [2:0]  count;

    always #5 clk = ~clk;

    fpu_issue_queue dut (
        .clk(clk), .reset(reset), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .core_start(core_start), .core_op(core_op), .core_a(core_a), .core_b(core_b),
        .core_busy(core_busy), .core_done(core_done), .core_result(core_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_tag(rsp_tag), .count(count)
    );

    int checks = 0;
    int passed = 0;

    function automatic logic [31:0] core_fn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        return a ^ b ^ 32'h3FC0_0000 ^ {op, 29'd0};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        else passed++;
    endtask

    task automatic fail_now(input string nm);
        checks++;
        $display("FAIL %s", nm);
    endtask

    // Toy core: done lat_cfg cycles after start (lat_cfg==0 means done in the start cycle).
    int          lat_cfg = 3;
    bit          busy_force = 0;
    int          rem = 0;
    logic        done_r = 1'b0, busy_r = 1'b0;
    logic [31:0] res_r = '0, pending = '0;

    assign core_busy   = busy_force | busy_r;
    assign core_done   = done_r | (core_start && (lat_cfg == 0));
    assign core_result = done_r ? res_r : core_fn(core_op, core_a, core_b);

    always @(negedge clk) begin
        if (reset && core_start && lat_cfg > 0) begin
            pending = core_fn(core_op, core_a, core_b);
            rem     = lat_cfg;
        end
    end

    always @(posedge clk) begin
        #1;
        done_r = 1'b0;
        if (rem > 0) begin
            rem--;
            if (rem == 0) begin
                done_r = 1'b1;
                res_r  = pending;
            end
        end
        busy_r = (rem > 0) || done_r;
    end

    // Reference model: queued requests and outstanding (issued, not yet consumed) responses.
    typedef struct { logic [2:0] op; logic [31:0] a; logic [31:0] b; logic [3:0] tag; } req_t;
    typedef struct { logic [31:0] res; logic [3:0] tag; } rsp_t;
    req_t mq[$];
    rsp_t rq[$];
    bit          hold_q = 0;
    logic [31:0] prev_res;
    logic [3:0]  prev_tag;

    always @(negedge clk) begin
        if (!reset) begin
            mq.delete();
            rq.delete();
            hold_q = 0;
        end else begin
            chk("count", 64'(count), 64'(mq.size()));
            if (hold_q)
                chk("rsp_hold", 64'({rsp_valid, rsp_result, rsp_tag}), 64'({1'b1, prev_res, prev_tag}));
            if (rsp_valid && rsp_ready) begin
                if (rq.size() == 0) begin
                    checks++;
                    $display("FAIL rsp_unexpected: got tag 0x%0h with nothing outstanding", rsp_tag);
                end else begin
                    chk("rsp_result", 64'(rsp_result), 64'(rq[0].res));
                    chk("rsp_tag", 64'(rsp_tag), 64'(rq[0].tag));
                    void'(rq.pop_front());
                end
            end
            if (core_start) begin
                if (mq.size() == 0 || flush) begin
                    fail_now("start_without_entry_or_during_flush");
                end else begin
                    chk("start_one_in_flight", 64'(rq.size()), 64'(0));
                    chk("start_op", 64'(core_op), 64'(mq[0].op));
                    chk("start_ab", {core_a, core_b}, {mq[0].a, mq[0].b});
                    rq.push_back('{core_fn(mq[0].op, mq[0].a, mq[0].b), mq[0].tag});
                    void'(mq.pop_front());
                end
            end
            if (flush) mq.delete();
            else if (req_valid && req_ready) mq.push_back('{req_op, req_a, req_b, req_tag});
            hold_q   = rsp_valid && !rsp_ready;
            prev_res = rsp_result;
            prev_tag = rsp_tag;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        step();
        #1;
    endtask

    task automatic push_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
        int n = 0;
        req_op = op; req_a = a; req_b = b; req_tag = tag; req_valid = 1'b1;
        #1;
        while (!req_ready && n < 50) begin cyc(); n++; end
        chk("push_accept", 64'(req_ready), 64'(1));
        step();
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int n = 0;
        #1;
        while (!rsp_valid && n < 40) begin cyc(); n++; end
        chk("rsp_arrives", 64'(rsp_valid), 64'(1));
    endtask

    typedef struct { logic [2:0] op; logic [31:0] a; logic [31:0] b; logic [3:0] tag; int lat; logic [31:0] exp_res; } vec_t;
    vec_t vt[6];

    function automatic vec_t mkvec(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag, input int lat);
        return '{op, a, b, tag, lat, core_fn(op, a, b)};
    endfunction

    logic [3:0] tags[$];
    int         cyc_rsp[$], cyc_start[$];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{3'd0, 32'h3F80_0000, 32'h4000_0000, 4'd5, 3, 32'h4040_0000};
        vt[1] = mkvec(3'd7, 32'hFFFF_FFFF, 32'h0000_0000, 4'd15, 0);
        vt[2] = mkvec(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 4'd0, 1);
        vt[3] = mkvec(3'd3, 32'h0000_0001, 32'h8000_0000, 4'd9, 2);
        vt[4] = mkvec(3'd5, 32'hDEAD_BEEF, 32'hCAFE_F00D, 4'd3, 0);
        vt[5] = mkvec(3'd2, 32'h7F7F_FFFF, 32'h0080_0000, 4'd12, 3);

        reset = 1'b0; flush = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        req_op = '0; req_a = '0; req_b = '0; req_tag = '0;
        #3;
        chk("reset_req_ready", 64'(req_ready), 64'(1));
        chk("reset_outputs", 64'({count, core_start, rsp_valid, rsp_result, rsp_tag}), 64'(0));
        step(); step();
        reset = 1'b1;
        step();

        // Single op with a 3-cycle core
        lat_cfg = 3;
        req_op = 3'd0; req_a = 32'h3F80_0000; req_b = 32'h4000_0000; req_tag = 4'd5; req_valid = 1'b1;
        #1 chk("single_no_start_early", 64'(core_start), 64'(0));
        step(); req_valid = 1'b0;
        #1 chk("single_start", 64'(core_start), 64'(1));
        cyc();  chk("single_start_width", 64'(core_start), 64'(0));
        cyc();  chk("single_rsp_early1", 64'(rsp_valid), 64'(0));
        cyc();  chk("single_rsp_early2", 64'(rsp_valid), 64'(0));
        cyc();  chk("single_rsp_valid", 64'(rsp_valid), 64'(1));
        chk("single_rsp_result", 64'(rsp_result), 64'h4040_0000);
        chk("single_rsp_tag", 64'(rsp_tag), 64'(5));
        cyc();  chk("single_rsp_held", 64'(rsp_valid), 64'(1));
        rsp_ready = 1'b1;
        cyc();  chk("single_rsp_cleared", 64'(rsp_valid), 64'(0));

        // Table-driven vectors over op/operand/tag boundaries and core latencies
        for (int i = 0; i < 6; i++) begin
            lat_cfg = vt[i].lat;
            push_req(vt[i].op, vt[i].a, vt[i].b, vt[i].tag);
            wait_rsp();
            chk("vec_result", 64'(rsp_result), 64'(vt[i].exp_res));
            chk("vec_tag", 64'(rsp_tag), 64'(vt[i].tag));
            step();
        end

        // Fill and backpressure with the core held busy
        busy_force = 1; lat_cfg = 2; rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1; req_tag = 4'(i); req_op = 3'(i); req_a = $urandom; req_b = $urandom;
            #1;
            if (i == 4) begin
                chk("fill_count", 64'(count), 64'(4));
                chk("fill_ready_5th", 64'(req_ready), 64'(0));
            end
            step();
        end
        req_valid = 1'b0; busy_force = 0;
        tags.delete();
        for (int c = 0; c < 60; c++) begin
            #1;
            if (rsp_valid && rsp_ready) tags.push_back(rsp_tag);
            step();
        end
        chk("fill_drain_n", 64'(tags.size()), 64'(4));
        for (int k = 0; k < 4; k++) chk("fill_drain_tag", 64'((k < tags.size()) ? tags[k] : 4'hF), 64'(k));

        // Response stall blocks the second issue
        rsp_ready = 1'b0; lat_cfg = 1;
        req_valid = 1'b1; req_tag = 4'd8; req_op = 3'd1; req_a = 32'h11; req_b = 32'h22; step();
        req_tag = 4'd9; req_op = 3'd2; req_a = 32'h33; req_b = 32'h44; step();
        req_valid = 1'b0;
        wait_rsp();
        chk("stall_first_tag", 64'(rsp_tag), 64'(8));
        for (int c = 0; c < 4; c++) begin
            cyc();
            chk("stall_no_start", 64'({rsp_valid, core_start}), 64'(2'b10));
        end
        rsp_ready = 1'b1;
        #1 chk("stall_release_start", 64'(core_start), 64'(1));
        step(); rsp_ready = 1'b0;
        #1 chk("stall_slot_cleared", 64'(rsp_valid), 64'(0));
        cyc();  chk("stall_second_rsp", 64'({rsp_valid, rsp_tag}), 64'({1'b1, 4'd9}));
        rsp_ready = 1'b1;
        step();

        // Same-cycle done: back-to-back single-cycle ops
        busy_force = 1; lat_cfg = 0;
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1; req_tag = 4'(10 + i); req_op = 3'(i); req_a = $urandom; req_b = $urandom;
            step();
        end
        req_valid = 1'b0; busy_force = 0;
        tags.delete(); cyc_rsp.delete(); cyc_start.delete();
        for (int c = 0; c < 20; c++) begin
            #1;
            if (core_start) cyc_start.push_back(c);
            if (rsp_valid && rsp_ready) begin cyc_rsp.push_back(c); tags.push_back(rsp_tag); end
            step();
        end
        chk("scd_rsp_n", 64'(cyc_rsp.size()), 64'(4));
        chk("scd_start_n", 64'(cyc_start.size()), 64'(4));
        if (cyc_rsp.size() == 4 && cyc_start.size() == 4) begin
            chk("scd_rsp_back_to_back", 64'(cyc_rsp[3] - cyc_rsp[0]), 64'(3));
            chk("scd_start_back_to_back", 64'(cyc_start[3] - cyc_start[0]), 64'(3));
            chk("scd_rsp_after_start", 64'(cyc_rsp[0] - cyc_start[0]), 64'(1));
            for (int k = 0; k < 4; k++) chk("scd_tag", 64'(tags[k]), 64'(10 + k));
        end

        // Flush with three queued and one in flight; a same-cycle push is dropped
        lat_cfg = 4;
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1; req_tag = 4'(1 + i); req_op = 3'(i); req_a = $urandom; req_b = $urandom;
            step();
        end
        req_tag = 4'd9; flush = 1'b1;
        #1 chk("flush_pre_count", 64'(count), 64'(3));
        chk("flush_ready_shown", 64'(req_ready), 64'(1));
        step(); flush = 1'b0; req_valid = 1'b0;
        #1 chk("flush_count_zero", 64'(count), 64'(0));
        tags.delete();
        for (int c = 0; c < 20; c++) begin
            #1;
            if (rsp_valid && rsp_ready) tags.push_back(rsp_tag);
            step();
        end
        chk("flush_rsp_n", 64'(tags.size()), 64'(1));
        if (tags.size() > 0) chk("flush_inflight_tag", 64'(tags[0]), 64'(1));

        // Randomised traffic against the scoreboard
        for (int c = 0; c < 800; c++) begin
            req_valid = ($urandom_range(0, 1) == 1);
            req_op = 3'($urandom); req_a = $urandom; req_b = $urandom; req_tag = 4'($urandom);
            rsp_ready = ($urandom_range(0, 9) < 7);
            flush = ($urandom_range(0, 39) == 0);
            lat_cfg = $urandom_range(0, 3);
            step();
        end
        req_valid = 1'b0; flush = 1'b0; rsp_ready = 1'b1;
        repeat (60) step();
        chk("random_drain_empty", 64'({mq.size(), rq.size()}), 64'(0));

        // Asynchronous reset while waiting on the core
        lat_cfg = 3;
        push_req(3'd6, 32'h0F0F_0F0F, 32'h5555_AAAA, 4'd7);
        wait_rsp();
        step();
        req_valid = 1'b1; req_tag = 4'd2; step();
        req_tag = 4'd4; step();
        req_valid = 1'b0;
        step();
        reset = 1'b0;
        #1 chk("areset_req_ready", 64'(req_ready), 64'(1));
        chk("areset_outputs", 64'({count, core_start, rsp_valid, rsp_result, rsp_tag}), 64'(0));
        step();
        reset = 1'b1;
        cyc_rsp.delete();
        for (int c = 0; c < 12; c++) begin
            #1;
            if (rsp_valid) cyc_rsp.push_back(c);
            step();
        end
        chk("areset_stale_done_ignored", 64'(cyc_rsp.size()), 64'(0));
        chk("areset_count", 64'(count), 64'(0));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
